// File: rtl/aes_core_sched.sv
// Round-robin front end that time-shares one AES core among several requesters.
// Sequences the core's level-enable handshake and returns ID-tagged ciphertext.
module aes_core_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     AES_clk,
  input  logic                     AES_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*128-1:0]   req_data,
  input  logic [NUM_REQ*128-1:0]   req_key,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [127:0]             resp_data,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_err,
  output logic                     core_en,
  output logic [127:0]             core_data,
  output logic [127:0]             core_key,
  input  logic [127:0]             core_out,
  input  logic                     core_out_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StResp, StGap} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    resp_data_q, resp_data_d;
  logic            err_q, err_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  int unsigned     idx;
  logic [NUM_REQ-1:0] hit;

  // First pending requester at or above rr_ptr, wrapping; shifts avoid out-of-range selects.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    hit         = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      hit = req_valid >> idx;
      if (!grant_found && hit[0]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    key_d       = key_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    req_ready   = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready = (NUM_REQ'(1) << grant_idx) & {NUM_REQ{AES_rst_n}};
          data_d    = 128'(req_data >> (32'(grant_idx) * 32'd128));
          key_d     = 128'(req_key >> (32'(grant_idx) * 32'd128));
          id_d      = grant_idx;
          rr_ptr_d  = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 8'd1;
        // A result arriving on the last allowed cycle still beats the watchdog.
        if (core_out_valid) begin
          resp_data_d = core_out;
          err_d       = 1'b0;
          state_d     = StResp;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          resp_data_d = '0;
          err_d       = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StGap;
      end
      StGap: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      key_q       <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      key_q       <= key_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  // Gating with the reset drops the core enable in the very first reset cycle.
  assign core_en    = (state_q == StRun) & AES_rst_n;
  assign resp_valid = (state_q == StResp) & AES_rst_n;
  assign core_data  = data_q;
  assign core_key   = key_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// Bench for aes_core_sched: behavioural core stub, response scoreboard, grant table
// and hand-written back-pressure / stray-valid / mid-run reset sequences.
module tb_aes_core_sched;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 16;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*128-1:0] req_data, req_key;
  logic [NR-1:0]     req_ready;
  logic              resp_valid, resp_ready;
  logic [127:0]      resp_data;
  logic [IW-1:0]     resp_id;
  logic              resp_err, core_en;
  logic [127:0]      core_data, core_key, core_out;
  logic              core_out_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_core_sched #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .AES_clk       (clk),
    .AES_rst_n     (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_key       (req_key),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_id       (resp_id),
    .resp_err      (resp_err),
    .core_en       (core_en),
    .core_data     (core_data),
    .core_key      (core_key),
    .core_out      (core_out),
    .core_out_valid(core_out_valid)
  );

  // Core stub: result valid on the core_lat-th enabled cycle; FIPS pair returns the real answer.
  int   core_lat = 4;
  int   mcnt = 0;
  logic stray = 1'b0;

  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (k == FIPS_K && d == FIPS_P) return FIPS_C;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  always @(posedge clk) begin
    if (!core_en) mcnt <= 0;
    else          mcnt <= mcnt + 1;
  end
  assign core_out_valid = (core_en && (mcnt == core_lat - 1)) || stray;
  assign core_out       = core_fn(core_data, core_key);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired without the required event", nm);
  endtask

  typedef struct {
    logic [127:0] data;
    logic [IW-1:0] id;
    logic          err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_g;

  // Scoreboard: push on accept, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n && req_ready != '0) begin
      mon_g = 0;
      for (int i = 0; i < NR; i++) if (req_ready[i]) mon_g = i;
      mon_e.id   = IW'(mon_g);
      mon_e.err  = (core_lat > TO);
      mon_e.data = mon_e.err ? '0 :
                   core_fn(req_data[mon_g*128 +: 128], req_key[mon_g*128 +: 128]);
      sb_q.push_back(mon_e);
    end
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        fail("unexpected_resp");
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_id", 128'(resp_id), 128'(mon_e.id));
        chk("resp_err", 128'(resp_err), 128'(mon_e.err));
      end
    end
  end

  task automatic set_data(input logic fips);
    for (int i = 0; i < NR; i++) begin
      req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      req_key[i*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
    end
    if (fips) begin
      req_data[127:0] = FIPS_P;
      req_key[127:0]  = FIPS_K;
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_req_ready"}, 128'(req_ready), '0);
    chk({nm, "_resp_valid"}, 128'(resp_valid), '0);
    chk({nm, "_resp_data"}, resp_data, '0);
    chk({nm, "_resp_id"}, 128'(resp_id), '0);
    chk({nm, "_resp_err"}, 128'(resp_err), '0);
    chk({nm, "_core_en"}, 128'(core_en), '0);
    chk({nm, "_core_data"}, core_data, '0);
    chk({nm, "_core_key"}, core_key, '0);
  endtask

  // Wait for a grant; returns found=0 if the bound expires.
  task automatic wait_grant(input int exp_g, output logic found);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (req_ready != '0) found = 1'b1;
    end
    if (!found) fail("grant_wait");
    else chk("grant", 128'(req_ready), 128'(4'b0001 << exp_g));
  endtask

  // Entered just after a rising edge with resp_ready high; leaves just after the edge into IDLE.
  task automatic do_txn(input logic [NR-1:0] mask, input int exp_g, input int lat,
                        input logic fips);
    logic found, got;
    int   run;
    logic [127:0] exp_d, exp_k;
    core_lat = lat;
    set_data(fips);
    exp_d = req_data[exp_g*128 +: 128];
    exp_k = req_key[exp_g*128 +: 128];
    req_valid = mask;
    wait_grant(exp_g, found);
    @(posedge clk); #1;
    req_valid = mask & ~(NR'(1) << exp_g);
    if (!found) return;
    run = 0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (run == 0) begin
          chk("core_data", core_data, exp_d);
          chk("core_key", core_key, exp_k);
        end
        chk("core_en_run", 128'(core_en), 128'(1));
        run++;
      end
    end
    if (!got) begin
      fail("resp_wait");
      return;
    end
    chk("run_cycles", 128'(run), 128'((lat > TO) ? TO : lat));
    chk("core_en_resp", 128'(core_en), '0);
    if (fips) chk("fips_ct", resp_data, FIPS_C);
    @(negedge clk);
    chk("core_en_gap", 128'(core_en), '0);
    chk("resp_valid_gap", 128'(resp_valid), '0);
    chk("req_ready_gap", 128'(req_ready), '0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            grant;
    int            lat;
    logic          fips;
  } vec_t;
  vec_t tbl[10];

  initial begin
    logic found, got;
    logic [127:0] hold_d;

    tbl[0] = '{4'b1111, 0, 4, 1'b0};
    tbl[1] = '{4'b1110, 1, 5, 1'b0};
    tbl[2] = '{4'b1100, 2, 1, 1'b0};
    tbl[3] = '{4'b1000, 3, 7, 1'b0};
    tbl[4] = '{4'b1010, 1, 3, 1'b0};
    tbl[5] = '{4'b1000, 3, 6, 1'b0};
    tbl[6] = '{4'b0001, 0, 10, 1'b1};
    tbl[7] = '{4'b0101, 2, 16, 1'b0};   // valid and timeout coincide
    tbl[8] = '{4'b0001, 0, 200, 1'b0};  // watchdog abort
    tbl[9] = '{4'b1001, 3, 2, 1'b0};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_key    = '0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_txn(tbl[i].mask, tbl[i].grant, tbl[i].lat, tbl[i].fips);
    req_valid = '0;

    // Stray core valid while idle must not create a response.
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_idle_resp", 128'(resp_valid), '0);
      chk("stray_idle_en", 128'(core_en), '0);
    end
    @(posedge clk); #1;
    stray = 1'b0;

    // Back-pressure: response held for 20 cycles with other requesters waiting.
    resp_ready = 1'b0;
    core_lat   = 5;
    set_data(1'b0);
    req_valid = 4'b0100;
    wait_grant(2, found);
    @(posedge clk); #1;
    req_valid = 4'b1011;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    if (!got) fail("bp_resp_wait");
    hold_d = (sb_q.size() != 0) ? sb_q[0].data : '1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_resp_valid", 128'(resp_valid), 128'(1));
      chk("bp_resp_data", resp_data, hold_d);
      chk("bp_resp_id", 128'(resp_id), 128'(2));
      chk("bp_core_en", 128'(core_en), '0);
      chk("bp_req_ready", 128'(req_ready), '0);
      @(posedge clk); #1;
      stray = (k == 5);
    end
    stray = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    stray = 1'b1;
    @(negedge clk);
    chk("gap_core_en", 128'(core_en), '0);
    chk("gap_req_ready", 128'(req_ready), '0);
    chk("gap_resp_valid", 128'(resp_valid), '0);
    @(posedge clk); #1;
    stray = 1'b0;
    do_txn(4'b1011, 3, 3, 1'b0);
    req_valid = '0;

    // Reset ten cycles into RUN discards the operation and the pointer.
    core_lat = 200;
    set_data(1'b0);
    req_valid = 4'b0010;
    wait_grant(1, found);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_first_core_en", 128'(core_en), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("midrst");
    repeat (30) begin
      @(negedge clk);
      chk("midrst_no_resp", 128'(resp_valid), '0);
    end
    @(posedge clk); #1;
    do_txn(4'b1111, 0, 3, 1'b0);
    req_valid = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
